// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encodings and the
// default datapath width used by the divider, multiplier and control unit.
package div_seq_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_FIXUP = 3'd3,
        S_ZERO  = 3'd4
    } state_t;

endpackage

// File: rtl/div_seq_abs.sv
// Magnitude extractor: two's-complement absolute value when signed, pass-through
// otherwise; neg reports whether the operand was negated.
module div_seq_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             is_signed,
    output logic [WIDTH-1:0] mag,
    output logic             neg
);

    assign neg = is_signed & in[WIDTH-1];
    assign mag = neg ? (~in + WIDTH'(1)) : in;

endmodule

// File: rtl/div_seq.sv
// Restoring sequential divider, one quotient bit per cycle; quotient to lo,
// remainder to hi, with busy/done handshake, sticky divide-by-zero and abort.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    input  logic             init,
    input  logic             stop,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divzero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             sgn_r;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] bm;
    logic             sq;
    logic             sr;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             neg_a;
    logic             neg_b;

    logic [WIDTH:0]   partial;
    logic [WIDTH+1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    div_seq_abs #(.WIDTH(WIDTH)) u_abs_a (
        .in        (a_r),
        .is_signed (sgn_r),
        .mag       (mag_a),
        .neg       (neg_a)
    );

    div_seq_abs #(.WIDTH(WIDTH)) u_abs_b (
        .in        (b_r),
        .is_signed (sgn_r),
        .mag       (mag_b),
        .neg       (neg_b)
    );

    // The shifted partial remainder keeps r's top bit, so it is WIDTH+1 bits
    // wide; one extra borrow bit makes the trial-subtract sign unambiguous.
    assign partial = {r, q[WIDTH-1]};
    assign diff    = {1'b0, partial} - {2'b00, bm};
    assign fits    = ~diff[WIDTH+1];
    assign r_next  = fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    assign q_next  = {q[WIDTH-2:0], fits};

    // NOTE: every register here is state, so all are written with <= and all
    // get a defined reset value -- nothing is left to power-up garbage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sgn_r   <= 1'b0;
            r       <= '0;
            q       <= '0;
            bm      <= '0;
            sq      <= 1'b0;
            sr      <= 1'b0;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state   <= S_IDLE;
                hi      <= '0;
                lo      <= '0;
                divzero <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (init) begin
                            a_r     <= a;
                            b_r     <= b;
                            sgn_r   <= is_signed;
                            divzero <= 1'b0;
                            busy    <= 1'b1;
                            state   <= (b == '0) ? S_ZERO : S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        r     <= '0;
                        q     <= mag_a;
                        bm    <= mag_b;
                        sq    <= neg_a ^ neg_b;
                        sr    <= neg_a;
                        cnt   <= CNT_W'(WIDTH);
                        state <= S_RUN;
                    end
                    S_RUN: begin
                        r   <= r_next;
                        q   <= q_next;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= S_FIXUP;
                        end
                    end
                    S_FIXUP: begin
                        // Truncating division: remainder follows the dividend's sign.
                        lo    <= sq ? (~q + WIDTH'(1)) : q;
                        hi    <= sr ? (~r + WIDTH'(1)) : r;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    S_ZERO: begin
                        hi      <= '0;
                        lo      <= '0;
                        divzero <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected results are queued at accept time and
// compared (values and latency) when done pulses.
module tb_div_seq;
    import div_seq_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         is_signed;
    logic         init;
    logic         stop;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         divzero;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         dz;
        int           due;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    div_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .init      (init),
        .stop      (stop),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy),
        .done      (done),
        .divzero   (divzero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference built on 64-bit signed arithmetic, which truncates toward zero.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic s, input string tag, input int due);
        exp_t   e;
        longint la;
        longint lb;
        e.tag = tag;
        e.due = due;
        e.dz  = 1'b0;
        if (ib == '0) begin
            e.lo = '0;
            e.hi = '0;
            e.dz = 1'b1;
        end else if (!s) begin
            e.lo = ia / ib;
            e.hi = ia % ib;
        end else begin
            la   = longint'($signed(ia));
            lb   = longint'($signed(ib));
            e.lo = W'(la / lb);
            e.hi = W'(la % lb);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_lo"}, lo, e.lo);
                check({e.tag, "_hi"}, hi, e.hi);
                check({e.tag, "_dz"}, divzero, e.dz);
                check({e.tag, "_lat"}, cyc, e.due);
                check({e.tag, "_busy_done"}, busy, 0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Called on a negedge with the DUT idle; returns on the following negedge.
    task automatic start(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic s);
        a         = ia;
        b         = ib;
        is_signed = s;
        init      = 1'b1;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic run_div(input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input logic s, input string tag);
        int lat;
        lat = (ib == '0) ? 1 : W + 2;
        sb.push_back(model(ia, ib, s, tag, cyc + 1 + lat));
        start(ia, ib, s);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_dzclr"}, divzero, 0);
    endtask

    initial begin
        #(10 * 20000);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        init      = 1'b0;
        stop      = 1'b0;
        #12;
        check("rst_lo", lo, 0);
        check("rst_hi", hi, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", divzero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_div(100, 7, 1'b0, "t1_u100_7");
        wait_idle();
        run_div(32'hFFFF_FFF9, 2, 1'b1, "t2_s_m7_2");
        wait_idle();
        run_div(32'hFFFF_FFF9, 2, 1'b0, "t2_u_m7_2");
        wait_idle();
        run_div(55, 0, 1'b0, "t3_div0");
        wait_idle();
        run_div(9, 3, 1'b0, "t3_9_3");
        wait_idle();
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "t4_min_m1");
        wait_idle();
        run_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, "big_u");
        wait_idle();
        run_div(7, 32'hFFFF_FFFE, 1'b1, "s_7_m2");
        wait_idle();
        run_div(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, "s_m7_m2");
        wait_idle();
        run_div(0, 5, 1'b1, "zero_dividend");
        wait_idle();
        run_div(32'h1234_5678, 32'h0000_0123, 1'b0, "u_mix");
        wait_idle();

        // init while busy must not disturb the in-flight operation
        run_div(1000, 9, 1'b0, "busy_init");
        repeat (3) @(negedge clk);
        start(5, 0, 1'b0);
        wait_idle();

        // stop while idle clears a sticky divzero
        run_div(55, 0, 1'b1, "dz_before_stop");
        wait_idle();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("idle_stop_dz", divzero, 0);

        // abort mid-run with an ignored re-init along the way
        run_div(9, 3, 1'b0, "pre_abort");
        wait_idle();
        start(100, 7, 1'b0);
        repeat (3) @(negedge clk);
        start(200, 3, 1'b0);
        repeat (4) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_lo", lo, 0);
        check("abort_hi", hi, 0);
        repeat (W + 6) @(negedge clk);

        // init and stop together: nothing starts
        a         = 100;
        b         = 7;
        init      = 1'b1;
        stop      = 1'b1;
        @(negedge clk);
        init = 1'b0;
        stop = 1'b0;
        check("init_stop_busy", busy, 0);
        repeat (W + 4) @(negedge clk);

        // stop on the FIXUP cycle discards the result
        run_div(9, 3, 1'b0, "pre_fixup_stop");
        wait_idle();
        start(100, 7, 1'b0);
        repeat (W + 1) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("fixup_stop_lo", lo, 0);
        check("fixup_stop_busy", busy, 0);
        repeat (4) @(negedge clk);

        // asynchronous reset in the middle of RUN
        run_div(9, 3, 1'b0, "pre_reset");
        wait_idle();
        start(100, 7, 1'b0);
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_lo", lo, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_dz", divzero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_div(100, 7, 1'b0, "t6_after_rst");
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
